execute_pipe: RTL and testbench

Parametrised, two-stage pipelined execute unit for the LC3-style datapath. It succeeds the fixed 16-bit single-cycle execute stage and adds generic datapath width, valid/ready handshakes on both sides, and backpressure-safe stalling. Operand selection and decode happen in stage 1 and are exported as probe outputs. ALU/shift/memory results are produced in stage 2. It sits between decode/register-read and writeback/memory.

---
 rtl/execute_pkg.sv | 36 +++
 rtl/execute_alu.sv | 70 +++++++
 rtl/execute_pipe.sv | 151 +++++++++++++++
 tb/tb_execute_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared encodings for the pipelined execute unit: opselect classes,
// arithmetic/shift operation codes and control_in field positions.
package execute_pkg;

  typedef enum logic [2:0] {
    SHIFT  = 3'b000,
    ARITH  = 3'b001,
    MEM_WR = 3'b100,
    MEM_RD = 3'b101
  } opselect_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_HADD = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_NOT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_LHG  = 3'd7
  } arith_op_e;

  typedef enum logic [2:0] {
    SH_SHL = 3'd0,
    SH_SHR = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3
  } shift_op_e;

  localparam int CTRL_OPSEL_LSB = 0;
  localparam int CTRL_OPSEL_MSB = 2;
  localparam int CTRL_OP_LSB    = 3;
  localparam int CTRL_OP_MSB    = 5;
  localparam int CTRL_IMM_SEL   = 6;

endpackage

// File: rtl/execute_alu.sv
// Combinational arithmetic/shift datapath fed by the stage-1 decode registers.
// Optional overflow output exists only when EXECUTE_PIPE_FLAGS_EN is defined.
module execute_alu
  import execute_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   aluin1,
  input  logic [WIDTH-1:0]   aluin2,
  input  logic [2:0]         operation,
  input  logic [SHAMT_W-1:0] shift_number,
  input  logic               enable_arith,
  input  logic               enable_shift,
`ifdef EXECUTE_PIPE_FLAGS_EN
  output logic               overflow,
`endif
  output logic [WIDTH-1:0]   result,
  output logic               carry
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH:0]       sum_full;
  logic [WIDTH:0]       diff_full;
  logic [HALF:0]        sum_half;
  logic [2*WIDTH-1:0]   rot_full;

  assign sum_full  = {1'b0, aluin1} + {1'b0, aluin2};
  assign diff_full = {1'b0, aluin1} - {1'b0, aluin2};
  assign sum_half  = {1'b0, aluin1[HALF-1:0]} + {1'b0, aluin2[HALF-1:0]};
  // Shifting a doubled copy leaves the rotated word in the upper half.
  assign rot_full  = {aluin1, aluin1} << shift_number;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    if (enable_arith) begin
      case (operation)
        ALU_ADD:  begin result = sum_full[WIDTH-1:0];  carry = sum_full[WIDTH]; end
        ALU_HADD: begin result = {{(WIDTH-HALF){1'b0}}, sum_half[HALF-1:0]}; carry = sum_half[HALF]; end
        ALU_SUB:  begin result = diff_full[WIDTH-1:0]; carry = diff_full[WIDTH]; end
        ALU_NOT:  result = ~aluin2;
        ALU_AND:  result = aluin1 & aluin2;
        ALU_OR:   result = aluin1 | aluin2;
        ALU_XOR:  result = aluin1 ^ aluin2;
        ALU_LHG:  result = {aluin2[HALF-1:0], {HALF{1'b0}}};
        default:  result = '0;
      endcase
    end else if (enable_shift) begin
      case (operation)
        SH_SHL:  result = aluin1 << shift_number;
        SH_SHR:  result = aluin1 >> shift_number;
        SH_SRA:  result = $signed(aluin1) >>> shift_number;
        SH_ROL:  result = rot_full[2*WIDTH-1:WIDTH];
        default: result = '0;
      endcase
    end
  end

`ifdef EXECUTE_PIPE_FLAGS_EN
  // Signed overflow: operand signs force the result sign, which disagrees.
  assign overflow = enable_arith &&
      (((operation == ALU_ADD) && (aluin1[WIDTH-1] == aluin2[WIDTH-1]) &&
        (sum_full[WIDTH-1] != aluin1[WIDTH-1])) ||
       ((operation == ALU_SUB) && (aluin1[WIDTH-1] != aluin2[WIDTH-1]) &&
        (diff_full[WIDTH-1] != aluin1[WIDTH-1])));
`endif

endmodule

// File: rtl/execute_pipe.sv
// Two-stage execute unit with valid/ready handshakes: stage 1 decodes, stage 2 computes.
// Define EXECUTE_PIPE_FLAGS_EN to add the registered zero/negative/overflow outputs.
module execute_pipe
  import execute_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_ex,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic [WIDTH-1:0]   imm,
  input  logic [6:0]         control_in,
  input  logic [WIDTH-1:0]   mem_data_read_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   aluout,
  output logic               carry,
  output logic [WIDTH-1:0]   mem_data_write_out,
  output logic               mem_write_en,
`ifdef EXECUTE_PIPE_FLAGS_EN
  output logic               zero,
  output logic               negative,
  output logic               overflow,
`endif
  output logic [WIDTH-1:0]   aluin1,
  output logic [WIDTH-1:0]   aluin2,
  output logic [2:0]         opselect,
  output logic [2:0]         operation,
  output logic [SHAMT_W-1:0] shift_number,
  output logic               enable_shift,
  output logic               enable_arith
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_src2_reg;
  logic [WIDTH-1:0] s1_imm_reg;

  logic             s2_free;
  logic             accept;
  logic             s1_move;
  logic [WIDTH-1:0] aluin2_next;
  logic [2:0]       opselect_next;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH-1:0] result_next;
  logic             store_next;
`ifdef EXECUTE_PIPE_FLAGS_EN
  logic             alu_overflow;
`endif

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !reset && enable_ex && (!s1_valid_reg || s2_free);
  assign accept   = in_valid && in_ready;
  assign s1_move  = enable_ex && s1_valid_reg && s2_free;

  assign aluin2_next   = control_in[CTRL_IMM_SEL] ? imm : src2;
  assign opselect_next = control_in[CTRL_OPSEL_MSB:CTRL_OPSEL_LSB];

  execute_alu #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .aluin1       (aluin1),
    .aluin2       (aluin2),
    .operation    (operation),
    .shift_number (shift_number),
    .enable_arith (enable_arith),
    .enable_shift (enable_shift),
`ifdef EXECUTE_PIPE_FLAGS_EN
    .overflow     (alu_overflow),
`endif
    .result       (alu_result),
    .carry        (alu_carry)
  );

  // Memory classes bypass the ALU; unlisted opselects fall through as zero.
  always_comb begin
    result_next = alu_result;
    store_next  = 1'b0;
    if (opselect == MEM_WR) begin
      result_next = aluin1 + s1_imm_reg;
      store_next  = 1'b1;
    end else if (opselect == MEM_RD) begin
      result_next = mem_data_read_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_reg       <= 1'b0;
      s1_src2_reg        <= '0;
      s1_imm_reg         <= '0;
      aluin1             <= '0;
      aluin2             <= '0;
      opselect           <= '0;
      operation          <= '0;
      shift_number       <= '0;
      enable_shift       <= 1'b0;
      enable_arith       <= 1'b0;
      out_valid          <= 1'b0;
      aluout             <= '0;
      carry              <= 1'b0;
      mem_data_write_out <= '0;
      mem_write_en       <= 1'b0;
`ifdef EXECUTE_PIPE_FLAGS_EN
      zero               <= 1'b0;
      negative           <= 1'b0;
      overflow           <= 1'b0;
`endif
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_src2_reg  <= src2;
        s1_imm_reg   <= imm;
        aluin1       <= src1;
        aluin2       <= aluin2_next;
        opselect     <= opselect_next;
        operation    <= control_in[CTRL_OP_MSB:CTRL_OP_LSB];
        shift_number <= aluin2_next[SHAMT_W-1:0];
        enable_arith <= (opselect_next == ARITH);
        enable_shift <= (opselect_next == SHIFT);
      end else if (s1_move) begin
        s1_valid_reg <= 1'b0;
      end

      // A downstream handshake retires the result even while enable_ex is low.
      if (s1_move) begin
        out_valid          <= 1'b1;
        aluout             <= result_next;
        carry              <= alu_carry;
        mem_data_write_out <= s1_src2_reg;
        mem_write_en       <= store_next;
`ifdef EXECUTE_PIPE_FLAGS_EN
        zero               <= (result_next == '0);
        negative           <= result_next[WIDTH-1];
        overflow           <= alu_overflow;
`endif
      end else if (out_valid && out_ready) begin
        out_valid    <= 1'b0;
        mem_write_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe (WIDTH = 16): directed scenarios plus
// randomized streams scored against an arithmetic reference model.
module tb_execute_pipe;

  logic        clock = 1'b0;
  logic        reset, enable_ex, in_valid, in_ready, out_valid, out_ready;
  logic        carry, mem_write_en, enable_shift, enable_arith;
  logic [15:0] src1, src2, imm, mem_data_read_in, aluout, mem_data_write_out;
  logic [15:0] aluin1, aluin2;
  logic [6:0]  control_in;
  logic [2:0]  opselect, operation;
  logic [3:0]  shift_number;

  always #5 clock = ~clock;

  execute_pipe #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable_ex(enable_ex),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .imm(imm), .control_in(control_in),
    .mem_data_read_in(mem_data_read_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluout(aluout), .carry(carry),
    .mem_data_write_out(mem_data_write_out), .mem_write_en(mem_write_en),
    .aluin1(aluin1), .aluin2(aluin2), .opselect(opselect), .operation(operation),
    .shift_number(shift_number), .enable_shift(enable_shift), .enable_arith(enable_arith)
  );

  typedef struct {
    int result;
    bit carry;
    bit store;
    int wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  bit          last_accept, have_prev, prev_en, prev_ov, prev_rdy;
  logic [15:0] prev_aluout;
  logic [6:0]  it_ctrl[64];
  logic [15:0] it_a[64], it_b[64], it_imm[64];

  // Reference: instruction semantics computed with plain integer arithmetic.
  function automatic exp_t model(logic [6:0] ctrl, int a, int s2, int im, int mem);
    exp_t e;
    int b, n, r;
    bit c;
    b = ctrl[6] ? im : s2;
    n = b % 16;
    r = 0;
    c = 0;
    e.store = 0;
    e.wdata = s2;
    case (ctrl[2:0])
      3'b001: case (ctrl[5:3])
        3'd0: begin r = a + b; c = (r > 65535); end
        3'd1: begin r = (a % 256) + (b % 256); c = (r > 255); r = r % 256; end
        3'd2: begin r = a - b; c = (a < b); end
        3'd3: r = 65535 - b;
        3'd4: r = a & b;
        3'd5: r = a | b;
        3'd6: r = a ^ b;
        default: r = (b % 256) * 256;
      endcase
      3'b000: case (ctrl[5:3])
        3'd0: r = a << n;
        3'd1: r = a >> n;
        3'd2: begin r = (a >= 32768) ? a - 65536 : a; r = r >>> n; end
        3'd3: r = (a << n) | (a >> (16 - n));
        default: r = 0;
      endcase
      3'b100: begin r = a + im; e.store = 1; end
      3'b101: r = mem;
      default: r = 0;
    endcase
    e.result = r & 32'hFFFF;
    e.carry  = c;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, score handshakes, then move past the rising edge.
  task automatic cycle();
    exp_t h;
    @(negedge clock);
    if (have_prev) begin
      if (!prev_en) check("frozen_valid", out_valid, prev_ov && !prev_rdy);
      if (prev_ov && !prev_rdy) begin
        check("hold_valid", out_valid, 1);
        check("hold_aluout", aluout, prev_aluout);
      end
    end
    check("in_ready", in_ready, enable_ex && (exp_q.size() < 2 || out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        h = exp_q[0];
        check("aluout", aluout, h.result);
        check("carry", carry, h.carry);
        check("mem_write_en", mem_write_en, h.store);
        if (h.store) check("mem_wdata", mem_data_write_out, h.wdata);
      end
    end else begin
      check("wen_qualified", mem_write_en, 0);
    end
    last_accept = in_valid && in_ready;
    if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (last_accept) exp_q.push_back(model(control_in, src1, src2, imm, mem_data_read_in));
    prev_en     = enable_ex;
    prev_ov     = out_valid;
    prev_rdy    = out_ready;
    prev_aluout = aluout;
    have_prev   = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [6:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] im);
    control_in = c;
    src1 = a;
    src2 = b;
    imm = im;
    in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_accept) break;
    end
    in_valid = 0;
    if (!last_accept) check("send_timeout", last_accept, 1);
  endtask

  task automatic run_stream(input int n, input int rlo, input int rhi, input int elo,
                            input int ehi, input bit rnd);
    int idx = 0;
    int cyc = 0;
    while ((idx < n || exp_q.size() > 0) && cyc < 3000) begin
      in_valid = (idx < n);
      if (idx < n) begin
        control_in = it_ctrl[idx];
        src1 = it_a[idx];
        src2 = it_b[idx];
        imm = it_imm[idx];
      end
      if (rnd) begin
        out_ready = ($urandom % 4) != 0;
        enable_ex = ($urandom % 6) != 0;
      end else begin
        out_ready = !(cyc >= rlo && cyc < rhi);
        enable_ex = !(cyc >= elo && cyc < ehi);
      end
      cycle();
      if (last_accept) idx++;
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
    enable_ex = 1;
    check("stream_drain", exp_q.size(), 0);
    check("stream_count", idx, n);
  endtask

  task automatic fill_random(input int n, input bit adds_only);
    for (int i = 0; i < n; i++) begin
      it_ctrl[i] = adds_only ? 7'b0_000_001 : 7'($urandom_range(0, 127));
      it_a[i]    = 16'($urandom);
      it_b[i]    = 16'($urandom);
      it_imm[i]  = 16'($urandom);
    end
  endtask

  initial begin
    reset = 1; enable_ex = 1; in_valid = 0; out_ready = 1;
    src1 = 0; src2 = 0; imm = 0; control_in = 0; mem_data_read_in = 0;
    have_prev = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_aluout", aluout, 0);
    check("rst_carry", carry, 0);
    check("rst_wen", mem_write_en, 0);
    check("rst_aluin1", aluin1, 0);
    check("rst_enable_arith", enable_arith, 0);
    reset = 0;

    // ADD with carry out; probes visible one cycle after accept, result one later
    send(7'b0_000_001, 16'hFFFF, 16'h0001, 16'h0000);
    check("add_probe_arith", enable_arith, 1);
    check("add_probe_aluin2", aluin2, 16'h0001);
    check("add_lat1_valid", out_valid, 0);
    cycle();
    check("add_lat2_valid", out_valid, 1);
    check("add_aluout", aluout, 16'h0000);
    check("add_carry", carry, 1);
    cycle();

    // Arithmetic right shift by immediate
    send(7'b1_010_000, 16'h8000, 16'h0000, 16'h0004);
    check("sra_shift_number", shift_number, 4);
    check("sra_enable_shift", enable_shift, 1);
    cycle();
    check("sra_aluout", aluout, 16'hF800);
    check("sra_carry", carry, 0);
    cycle();

    // Store: address from src1 + imm, data from src2, one strobe per handshake
    send(7'b0_000_100, 16'h3000, 16'hBEEF, 16'h0010);
    cycle();
    check("st_aluout", aluout, 16'h3010);
    check("st_wdata", mem_data_write_out, 16'hBEEF);
    check("st_wen", mem_write_en, 1);
    cycle();
    check("st_wen_after", mem_write_en, 0);

    // Four back-to-back ADDs with out_ready low for the first three cycles
    fill_random(4, 1);
    run_stream(4, 0, 3, -1, -1, 0);

    // enable_ex low for two cycles mid-stream
    fill_random(6, 0);
    run_stream(6, -1, -1, 2, 4, 0);

    // Random mixes under random backpressure and enable gaps
    for (int b = 0; b < 3; b++) begin
      mem_data_read_in = 16'($urandom);
      fill_random(40, 0);
      run_stream(40, -1, -1, -1, -1, 1);
    end

    // Reset with both stages holding stores and downstream stalled
    out_ready = 0;
    send(7'b0_000_100, 16'h1234, 16'hCAFE, 16'h0004);
    send(7'b0_000_100, 16'h2000, 16'h5555, 16'h0008);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_wen", mem_write_en, 1);
    reset = 1;
    @(posedge clock);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_wen", mem_write_en, 0);
    check("midrst_aluout", aluout, 0);
    check("midrst_in_ready", in_ready, 0);
    reset = 0;
    exp_q.delete();
    have_prev = 0;
    out_ready = 1;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
